// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor.
// Operands are captured on accept, then processed DIGIT bits per cycle, least
// significant digit first. The carry (add) or borrow (sub) is chained between
// digits. res and the flags are written only when the last digit completes,
// so partial results never appear on res.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] res,
    output logic             cb_out,
    output logic             ovf,
    output logic             zero,
    output logic             done
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             chain_q, chain_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cb_out_q, cb_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
    logic [DIGIT:0]   dig_ext_s;
    logic             chain_next_s;
    logic [WIDTH-1:0] dig_wide_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             ovf_next_s;

    // One digit of add/sub on the low digit of the operand shift registers.
    always_comb begin
        a_dig_s = a_q[DIGIT-1:0];
        b_dig_s = b_q[DIGIT-1:0];
        if (sub_q) begin
            // Top bit of the extended difference is the borrow out of this digit.
            dig_ext_s = {1'b0, a_dig_s} - {1'b0, b_dig_s} - {{DIGIT{1'b0}}, chain_q};
        end else begin
            dig_ext_s = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, chain_q};
        end
        chain_next_s = dig_ext_s[DIGIT];
        // New digit enters at the top; after N shifts the LSB digit sits at bit 0.
        dig_wide_s   = WIDTH'(dig_ext_s[DIGIT-1:0]);
        dig_wide_s   = dig_wide_s << (WIDTH - DIGIT);
        acc_next_s   = (acc_q >> DIGIT) | dig_wide_s;
        if (sub_q) begin
            ovf_next_s = (a_msb_q != b_msb_q) && (acc_next_s[WIDTH-1] != a_msb_q);
        end else begin
            ovf_next_s = (a_msb_q == b_msb_q) && (acc_next_s[WIDTH-1] != a_msb_q);
        end
    end

    // Next-state and next-output computation for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        chain_d  = chain_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        res_d    = res_q;
        cb_out_d = cb_out_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    chain_d = 1'b0;
                    idx_d   = {IDX_W{1'b0}};
                    acc_d   = {WIDTH{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                chain_d = chain_next_s;
                acc_d   = acc_next_s;
                if (idx_q == LAST_IDX) begin
                    state_d  = S_DONE;
                    res_d    = acc_next_s;
                    cb_out_d = chain_next_s;
                    ovf_d    = ovf_next_s;
                    zero_d   = (acc_next_s == {WIDTH{1'b0}});
                    done_d   = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d != S_RUN);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            sub_q    <= 1'b0;
            chain_q  <= 1'b0;
            idx_q    <= {IDX_W{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            res_q    <= {WIDTH{1'b0}};
            cb_out_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            chain_q  <= chain_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            res_q    <= res_d;
            cb_out_q <= cb_out_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign start_ready = ready_q;
    assign res         = res_q;
    assign cb_out      = cb_out_q;
    assign ovf         = ovf_q;
    assign zero        = zero_q;
    assign done        = done_q;

endmodule
